// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and overflow take a 1-cycle path.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_divop,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dsr_q;
    logic            is_rem_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            valid_q;
    logic [XLEN-1:0] result_q;

    logic            signed_op;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] spec_res;

    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quot_d;
    logic [XLEN-1:0] res_fin;

    assign o_ready  = (state_q == IDLE) && i_rst_n;
    assign o_valid  = valid_q;
    assign o_result = result_q;

    // Accept-time operand conditioning and special-case result selection.
    always_comb begin
        signed_op = ~i_divop[0];
        mag1      = (signed_op && i_src1[XLEN-1]) ? -i_src1 : i_src1;
        mag2      = (signed_op && i_src2[XLEN-1]) ? -i_src2 : i_src2;
        div_zero  = (i_src2 == '0);
        ovf       = signed_op && (i_src1 == MIN_NEG) && (&i_src2);
        if (div_zero) begin
            spec_res = i_divop[1] ? i_src1 : '1;
        end else begin
            spec_res = i_divop[1] ? '0 : i_src1;
        end
    end

    // One restoring step: shift in dividend MSB, subtract divisor if it fits.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[XLEN-1]};
        ge      = (rem_sh >= {1'b0, dsr_q});
        rem_d   = ge ? (rem_sh[XLEN-1:0] - dsr_q) : rem_sh[XLEN-1:0];
        quot_d  = {dvd_q[XLEN-2:0], ge};
        if (is_rem_q) begin
            res_fin = r_neg_q ? -rem_d : rem_d;
        end else begin
            res_fin = q_neg_q ? -quot_d : quot_d;
        end
    end

    // Control FSM with registered result and valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (i_flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        cnt_q    <= '0;
                        rem_q    <= '0;
                        dvd_q    <= mag1;
                        dsr_q    <= mag2;
                        is_rem_q <= i_divop[1];
                        q_neg_q  <= (i_divop == 2'b00) &
                                    (i_src1[XLEN-1] ^ i_src2[XLEN-1]);
                        r_neg_q  <= (i_divop == 2'b10) & i_src1[XLEN-1];
                        if (div_zero || ovf) begin
                            result_q <= spec_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= quot_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_q <= res_fin;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed test for div_unit.
// Hand-computed vectors, latency, backpressure, flush and reset recovery.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [1:0]  divop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_divop (divop),
        .i_src1  (src1),
        .i_src2  (src2),
        .i_flush (flush),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        divop    = op;
        src1     = a;
        src2     = b;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        src1     = 32'hDEAD_BEEF;
        src2     = 32'h0BAD_F00D;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_out && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp);
        tick();
        check({tag, "_rdy"}, {31'd0, ready_out}, 32'd1);
        check({tag, "_vld"}, {31'd0, valid_out}, 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        divop    = 2'b00;
        src1     = '0;
        src2     = '0;
        flush    = 1'b0;
        ready_in = 1'b1;
        tick();
        tick();
        check("rst_ready", {31'd0, ready_out}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_rel_ready", {31'd0, ready_out}, 32'd1);

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 1);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_min_1", 2'b01, 32'h8000_0000, 32'd1, 32'h8000_0000, 33);
        run_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

        // Backpressure in DONE.
        ready_in = 1'b0;
        issue(2'b01, 32'd100, 32'd7);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'd0, valid_out}, 32'd1);
            check("bp_result", result, 32'd14);
            check("bp_ready", {31'd0, ready_out}, 32'd0);
        end
        ready_in = 1'b1;
        tick();
        check("bp_rel_ready", {31'd0, ready_out}, 32'd1);
        check("bp_rel_valid", {31'd0, valid_out}, 32'd0);

        // Flush coincident with a request blocks the accept.
        flush    = 1'b1;
        divop    = 2'b01;
        src1     = 32'd9;
        src2     = 32'd0;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        flush    = 1'b0;
        check("flush_blk_ready", {31'd0, ready_out}, 32'd1);
        check("flush_blk_valid", {31'd0, valid_out}, 32'd0);

        // Flush mid-CALC.
        issue(2'b01, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", {31'd0, ready_out}, 32'd1);
        check("flush_valid", {31'd0, valid_out}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_out) seen = 1'b1;
        end
        check("flush_no_valid", {31'd0, seen}, 32'd0);
        run_op("post_flush", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // Reset mid-CALC.
        issue(2'b01, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        check("mrst_ready_low", {31'd0, ready_out}, 32'd0);
        check("mrst_result", result, 32'd0);
        rst_n = 1'b1;
        #1;
        check("mrst_ready", {31'd0, ready_out}, 32'd1);
        check("mrst_valid", {31'd0, valid_out}, 32'd0);
        run_op("post_rst", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
